// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and fetch FSM state type for the audio playback path.
package audio_pkg;
  localparam int DEF_ADDR_W = 14;
  localparam int DEF_SAMPLE_W = 16;
  localparam int FRAME_SLOTS = 64;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} fetch_state_t;
endpackage

// File: rtl/i2s_tx_serializer.sv
// i2s_tx_serializer: BCLK divider, 64-slot frame counter and one-bit-delayed I2S
// serialiser; pulls a new stereo word from the holding register at each frame boundary.
module i2s_tx_serializer import audio_pkg::*; #(
  parameter int BCLK_HALF_DIV = 12,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  enable_i,
  input  logic [2*SAMPLE_W-1:0] hold_data_i,
  input  logic                  hold_valid_i,
  output logic                  take_o,
  output logic                  starve_o,
  output logic                  bclk_o,
  output logic                  lrck_o,
  output logic                  dat_o
);
  localparam int DW = $clog2(BCLK_HALF_DIV + 1);
  logic [DW-1:0] div_q;
  logic [5:0] bit_q, n;
  logic [4:0] idx;
  logic [2*SAMPLE_W-1:0] frame_q;
  logic bclk_q, lrck_q, dat_q, dat_d, in_slot, tc, fall, boundary;
  assign tc = div_q == DW'(BCLK_HALF_DIV - 1);
  assign fall = tc & bclk_q;
  assign boundary = fall & (bit_q == 6'(FRAME_SLOTS - 1));
  assign take_o = boundary & enable_i & hold_valid_i;
  assign starve_o = boundary & enable_i & ~hold_valid_i;
  // n is the slot being entered; each half carries its sample in slots 1..SAMPLE_W
  always_comb begin
    n = bit_q + 6'd1;
    in_slot = (n[4:0] != 5'd0) && (int'(n[4:0]) <= SAMPLE_W);
    idx = 5'((n[5] ? SAMPLE_W : 2 * SAMPLE_W) - int'(n[4:0]));
    dat_d = in_slot & frame_q[idx];
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      bclk_q <= 1'b0;
      bit_q <= '0;
      lrck_q <= 1'b0;
      dat_q <= 1'b0;
      frame_q <= '0;
    end else begin
      div_q <= tc ? '0 : div_q + 1'b1;
      if (tc) bclk_q <= ~bclk_q;
      if (fall) begin
        bit_q <= n;
        lrck_q <= n[5];
        dat_q <= dat_d;
      end
      if (boundary) frame_q <= take_o ? hold_data_i : '0;
    end
  end
  assign bclk_o = bclk_q;
  assign lrck_o = lrck_q;
  assign dat_o = dat_q;
endmodule

// File: rtl/audio_stream_reader.sv
// audio_stream_reader: fetches stereo words from the sample RAM ring buffer up to the
// CPU write pointer and streams them to the WM8731 DAC over I2S.
module audio_stream_reader import audio_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BCLK_HALF_DIV = 12,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] audio_mem_s2_address,
  output logic              audio_mem_s2_chipselect,
  output logic              audio_mem_s2_clken,
  output logic              audio_mem_s2_write,
  output logic [31:0]       audio_mem_s2_writedata,
  output logic [3:0]        audio_mem_s2_byteenable,
  input  logic [31:0]       audio_mem_s2_readdata,
  output logic [31:0]       audio_position,
  input  logic [31:0]       audio_position_end,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              underrun
);
  fetch_state_t state_q;
  logic [ADDR_W-1:0] pos_q;
  logic [31:0] hold_q;
  logic hold_valid_q, cs_q, underrun_q, take, starve, unused_end;
  assign unused_end = ^audio_position_end[31:ADDR_W];
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q <= IDLE;
      pos_q <= '0;
      hold_q <= '0;
      hold_valid_q <= 1'b0;
      cs_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (enable && !hold_valid_q && pos_q != audio_position_end[ADDR_W-1:0]) begin
          state_q <= REQ;
          cs_q <= 1'b1;
        end
        REQ: begin
          state_q <= WAIT;
          cs_q <= 1'b0;
        end
        WAIT: begin
          state_q <= IDLE;
          hold_q <= audio_mem_s2_readdata;
          pos_q <= pos_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      // a frame load can never consume the word being captured: REQ needs an empty holder
      hold_valid_q <= (state_q == WAIT) | (hold_valid_q & ~take);
      underrun_q <= enable & (underrun_q | starve);
    end
  end
  i2s_tx_serializer #(.BCLK_HALF_DIV(BCLK_HALF_DIV), .SAMPLE_W(SAMPLE_W)) u_ser (
    .clk_i(clk_clk),
    .rst_ni(reset_reset_n),
    .enable_i(enable),
    .hold_data_i(hold_q),
    .hold_valid_i(hold_valid_q),
    .take_o(take),
    .starve_o(starve),
    .bclk_o(aud_bclk),
    .lrck_o(aud_daclrck),
    .dat_o(aud_dacdat)
  );
  assign audio_mem_s2_address = pos_q;
  assign audio_mem_s2_chipselect = cs_q;
  assign audio_mem_s2_clken = 1'b1;
  assign audio_mem_s2_write = 1'b0;
  assign audio_mem_s2_writedata = '0;
  assign audio_mem_s2_byteenable = 4'hF;
  assign audio_position = {{(32 - ADDR_W){1'b0}}, pos_q};
  assign underrun = underrun_q;
endmodule

// File: doc/audio_stream_reader.md
Name: audio_stream_reader

Overview:
- Playback engine on the far side of the audio sample RAM. Nios II writes 32-bit stereo words into the RAM and advances audio_position_end; this block reads words through the RAM's second port, serialises them to the WM8731 DAC in I2S format, and reports its read pointer on audio_position.
- It sits in the top level, next to the VGA sprite logic, outside the Qsys system.

Parameters:
- ADDR_W, 14: RAM word-address width; the ring buffer holds 2^ADDR_W words.
- BCLK_HALF_DIV, 12: clk_clk cycles per BCLK half-period. 50 MHz / 24 / 64 gives 32.55 kHz.
- SAMPLE_W, 16: bits per channel; word = {left[31:16], right[15:0]}.

Ports:
- clk_clk  in  1  system clock, 50 MHz
- reset_reset_n  in  1  asynchronous, active-low reset
- enable  in  1  playback enable (level)
- audio_mem_s2_address  out  ADDR_W  RAM read address
- audio_mem_s2_chipselect  out  1  RAM select, high only during a read request
- audio_mem_s2_clken  out  1  tied 1
- audio_mem_s2_write  out  1  tied 0
- audio_mem_s2_writedata  out  32  tied 0
- audio_mem_s2_byteenable  out  4  tied 4'hF
- audio_mem_s2_readdata  in  32  RAM data, valid 1 cycle after the request
- audio_position  out  32  next word index to fetch; bits [31:ADDR_W] are 0
- audio_position_end  in  32  CPU write pointer; only [ADDR_W-1:0] compared
- aud_bclk  out  1  I2S bit clock
- aud_daclrck  out  1  frame clock: 0 = left, 1 = right
- aud_dacdat  out  1  serial data
- underrun  out  1  sticky; cleared when enable is low

Behaviour:
- Reset: every output 0 except the tied constants. Position, bit counter, holding and frame registers are 0. Fetch FSM is IDLE.
- Clock divider:
  - Counter runs 0..BCLK_HALF_DIV-1 and toggles aud_bclk at terminal count.
  - A "fall" strobe marks the clk_clk cycle in which aud_bclk goes 1->0.
- Bit counter (6 bits):
  - Advances on each fall and wraps 63->0.
  - aud_daclrck = bit_cnt[5], updated on the same fall.
- Frame register (32 bits), loaded on the fall that takes bit_cnt 63->0:
  - from the holding register if hold_valid=1 and enable=1; hold_valid then clears;
  - with 0 otherwise. If enable=1 and hold_valid=0, underrun sets.
- I2S output (one-bit delay), driven on the fall into slot n:
  - n=1..16: aud_dacdat = frame[32-n] (left, MSB first);
  - n=33..48: aud_dacdat = frame[48-n] (right, MSB first);
  - all other slots: 0.
- Fetch FSM:
  - IDLE -> REQ when enable=1, hold_valid=0 and pos != end[ADDR_W-1:0].
  - REQ: one cycle with chipselect=1 and address=pos, then -> WAIT.
  - WAIT: capture readdata into the holding register, set hold_valid, pos = pos+1 mod 2^ADDR_W, then -> IDLE.
  - Fetch latency is 3 clk_clk cycles, far below one frame (1536 cycles).
- Empty (pos == end): no fetch is issued; silence frames follow once the holding register drains. Playback resumes automatically when end moves.
- Wrap-around: pos 2^ADDR_W-1 -> 0. The CPU owns the full/overrun condition; the block never compares beyond equality.
- Simultaneous events:
  - A frame-load consuming the holding register in the same cycle as a WAIT capture cannot occur, because REQ requires hold_valid=0.
  - A frame load in the WAIT cycle uses the old hold_valid (0): the frame gets silence and underrun sets.
- enable falls: no new REQ is issued. An in-flight WAIT completes. The next frame boundary loads silence. pos is retained. underrun clears while enable=0.
- Reset mid-frame: immediate return to reset values. The DAC resynchronises on the next LRCK edge.

Decomposition:
- Package audio_pkg holds: ADDR_W default, SAMPLE_W, FRAME_SLOTS=64, and typedef enum fetch_state_t {IDLE, REQ, WAIT}.
- Sub-module i2s_tx_serializer contains the divider, bit counter, frame register, aud_* outputs, and the frame_load/take handshake.
- The top contains the fetch FSM, position and underrun.

Test Plan:
1. Reset held, then released with enable=0 -> all outputs 0, audio_position=0, no chipselect pulse over 5000 cycles.
2. RAM[0]=32'hA5A5_3C3C, end=1, enable=1:
   - exactly one chipselect pulse at address 0, then audio_position=1;
   - after the next frame boundary, slots 1..16 carry 1010010110100101 and slots 33..48 carry 0011110000111100.
3. end=0 with enable=1 -> no RAM reads, aud_dacdat constant 0, underrun=1 after the first frame boundary; dropping enable clears underrun.
4. Preset pos=16383 (reset, then end=16383 and drained), RAM[16383]=1, end=0 -> read at address 16383, audio_position wraps to 0, right sample LSB is 1.
5. end=100 during steady play -> one read per 64-BCLK frame; frame period = 1536 clk_clk cycles; aud_daclrck is high for 768 cycles; position stops at 100 and silence follows.
6. reset_reset_n pulsed low mid-fetch (during WAIT) -> outputs 0 asynchronously; audio_position=0 after release; no holding data survives.
